// File: rtl/hs_sequencer_mc_if.sv
// Handshake and lane bus between the HS TX controller, the sequencer and the symbol mappers.
// The controller side uses the master modport; the sequencer uses the slave modport.
interface hs_sequencer_mc_if #(
    parameter int unsigned LANES    = 3,
    parameter int unsigned CNT_W    = 6,
    parameter int unsigned PROG_LEN = 14
);
    logic                  Sequencer_En;
    logic                  Sync;
    logic                  Post;
    logic [CNT_W-1:0]      Pre_Len;
    logic                  Prog_En;
    logic [3*PROG_LEN-1:0] Prog_Seq;
    logic [LANES-1:0]      Lane_Mask;
    logic [3*LANES-1:0]    SeqSym;
    logic [LANES-1:0]      SeqValid;
    logic                  Pre_Done;
    logic                  Sync_Done;
    logic                  Post_Done;
    logic                  Busy;

    modport master (
        output Sequencer_En, Sync, Post, Pre_Len, Prog_En, Prog_Seq, Lane_Mask,
        input  SeqSym, SeqValid, Pre_Done, Sync_Done, Post_Done, Busy
    );

    modport slave (
        input  Sequencer_En, Sync, Post, Pre_Len, Prog_En, Prog_Seq, Lane_Mask,
        output SeqSym, SeqValid, Pre_Done, Sync_Done, Post_Done, Busy
    );
endinterface

// File: rtl/hs_sequencer_mc.sv
// Multi-lane C-PHY HS sequencer: preamble (optionally programmable), sync word and post
// sequence driven in lock-step on all enabled lanes, with registered outputs.
module hs_sequencer_mc #(
    parameter int unsigned  LANES       = 3,
    parameter int unsigned  PRE_LEN_MAX = 63,
    parameter int unsigned  PROG_LEN    = 14,
    parameter int unsigned  PRE_END_LEN = 7,
    parameter int unsigned  POST_LEN    = 7,
    localparam int unsigned CNT_W       = $clog2(PRE_LEN_MAX + 1)
) (
    input logic               SymClk,
    input logic               reset,
    hs_sequencer_mc_if.slave  bus
);
    localparam int unsigned MaxA   = (PRE_LEN_MAX > PROG_LEN) ? PRE_LEN_MAX : PROG_LEN;
    localparam int unsigned MaxB   = (PRE_END_LEN > POST_LEN) ? PRE_END_LEN : POST_LEN;
    localparam int unsigned MaxC   = (MaxB > 7) ? MaxB : 7;
    localparam int unsigned MaxLen = (MaxA > MaxC) ? MaxA : MaxC;
    localparam int unsigned CW     = $clog2(MaxLen + 1);

    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;

    typedef enum logic [3:0] {
        StIdle, StPre, StProg, StPreEnd, StPreHold, StSync, StSyncHold, StPost, StPostHold
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             prog_en_q;
    logic [LANES-1:0] mask_q;

    logic [2:0]         sym_c;
    logic               vld_c;
    logic [2:0]         prog_sym;
    int unsigned        prog_idx;
    logic [3*LANES-1:0] lane_sym;
    logic [LANES-1:0]   lane_vld;

    // Outputs are a registered copy of what the current state emits, so they trail state by one edge.
    always_comb begin
        sym_c    = 3'd0;
        vld_c    = 1'b0;
        prog_sym = 3'd0;
        prog_idx = PROG_LEN - 1 - int'(cnt_q);
        for (int unsigned i = 0; i < PROG_LEN; i++) begin
            if (i == prog_idx) prog_sym = bus.Prog_Seq[3*i +: 3];
        end
        unique case (state_q)
            StPre, StPreEnd, StPreHold: begin sym_c = S3; vld_c = 1'b1; end
            StProg:                     begin sym_c = prog_sym; vld_c = 1'b1; end
            // Sync word 3,4,4,4,4,4,3: first and last symbol are S3.
            StSync: begin
                sym_c = (cnt_q == CW'(6) || cnt_q == '0) ? S3 : S4;
                vld_c = 1'b1;
            end
            StPost:                     begin sym_c = S4; vld_c = 1'b1; end
            StSyncHold, StPostHold:     begin sym_c = S4; vld_c = 1'b0; end
            default:                    begin sym_c = 3'd0; vld_c = 1'b0; end
        endcase
        lane_sym = '0;
        lane_vld = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sym[3*k +: 3] = mask_q[k] ? sym_c : 3'd0;
            lane_vld[k]        = mask_q[k] & vld_c;
        end
    end

    always_ff @(posedge SymClk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            prog_en_q     <= 1'b0;
            mask_q        <= '0;
            bus.SeqSym    <= '0;
            bus.SeqValid  <= '0;
            bus.Pre_Done  <= 1'b0;
            bus.Sync_Done <= 1'b0;
            bus.Post_Done <= 1'b0;
            bus.Busy      <= 1'b0;
        end else if (!bus.Sequencer_En) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            bus.SeqSym    <= '0;
            bus.SeqValid  <= '0;
            bus.Pre_Done  <= 1'b0;
            bus.Sync_Done <= 1'b0;
            bus.Post_Done <= 1'b0;
            bus.Busy      <= 1'b0;
        end else begin
            bus.Busy      <= 1'b1;
            bus.SeqSym    <= lane_sym;
            bus.SeqValid  <= lane_vld;
            bus.Pre_Done  <= bus.Pre_Done  | (state_q == StPreHold);
            bus.Sync_Done <= bus.Sync_Done | (state_q == StSyncHold);
            bus.Post_Done <= bus.Post_Done | (state_q == StPostHold);
            unique case (state_q)
                StIdle: begin
                    state_q   <= StPre;
                    cnt_q     <= (bus.Pre_Len == '0) ? '0 : CW'(bus.Pre_Len - 1'b1);
                    prog_en_q <= bus.Prog_En;
                    mask_q    <= bus.Lane_Mask;
                end
                StPre: begin
                    if (cnt_q == '0) begin
                        state_q <= prog_en_q ? StProg : StPreHold;
                        cnt_q   <= prog_en_q ? CW'(PROG_LEN - 1) : '0;
                    end else cnt_q <= cnt_q - 1'b1;
                end
                StProg: begin
                    if (cnt_q == '0) begin
                        state_q <= StPreEnd;
                        cnt_q   <= CW'(PRE_END_LEN - 1);
                    end else cnt_q <= cnt_q - 1'b1;
                end
                StPreEnd: begin
                    if (cnt_q == '0) state_q <= StPreHold;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                StPreHold: begin
                    if (bus.Sync) begin
                        state_q <= StSync;
                        cnt_q   <= CW'(6);
                    end else if (bus.Post) begin
                        state_q <= StPost;
                        cnt_q   <= CW'(POST_LEN - 1);
                    end
                end
                StSync: begin
                    if (cnt_q == '0) state_q <= StSyncHold;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                StSyncHold: begin
                    if (bus.Post) begin
                        state_q <= StPost;
                        cnt_q   <= CW'(POST_LEN - 1);
                    end
                end
                StPost: begin
                    if (cnt_q == '0) state_q <= StPostHold;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                StPostHold: state_q <= StPostHold;
                default:    state_q <= StIdle;
            endcase
        end
    end
endmodule
